fft_output_sequencer: RTL
=========================

// Module: fft_output_sequencer
// PURPOSE
//  Sequences the unload of a completed FFT frame from the result RAM to the downstream consumer.
//  - Starts on fft_done.
//  - Reads N_POINTS complex results, one at a time, and presents each on a valid/ready interface.
//  - Pulses output_strobe per accepted sample, output_done at frame end.
//  - Drives the sample-out count consumed by the output bookkeeping logic.
// PARAMETERS
//  N_POINTS  64  FFT length; must be a power of two
//  ADDR_W    6   log2(N_POINTS); result RAM address width
//  DATA_W    16  width of each real/imag component
// PORTS
//  clk                    in   1         system clock; all logic on rising edge
//  reset                  in   1         synchronous, active-high reset
//  fft_done               in   1         1-cycle pulse: frame in result RAM is complete
//  rd_en                  out  1         result RAM read enable
//  rd_addr                out  ADDR_W    result RAM read address
//  rd_data                in   2*DATA_W  {re,im}; valid the cycle after rd_en
//  out_valid              out  1         out_data holds a sample
//  out_ready              in   1         consumer accepts when out_valid && out_ready
//  out_data               out  2*DATA_W  registered sample {re,im}
//  out_last               out  1         high with out_valid on sample N_POINTS-1
//  output_strobe          out  1         1-cycle pulse on each accepted sample
//  output_done            out  1         1-cycle pulse after the last sample is accepted
//  samples_out_count_out  out  ADDR_W    samples accepted so far in the current frame
//  busy                   out  1         high in any state except IDLE
//  overrun                out  1         sticky: fft_done arrived while busy
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; internal index idx=0.
//  FSM states:
//  - IDLE: wait. fft_done -> FETCH; idx<=0; samples_out_count_out<=0; overrun<=0.
//  - FETCH: rd_en=1, rd_addr=map(idx). -> CAPTURE.
//  - CAPTURE: out_data<=rd_data; out_valid<=1; out_last<=(idx==N_POINTS-1). -> PRESENT.
//  - PRESENT: hold out_valid/out_data stable until out_ready.
//    - On handshake: output_strobe<=1 (pulse next cycle); out_valid<=0; count<=count+1.
//    - If idx==N_POINTS-1 -> DONE; else idx<=idx+1 -> FETCH.
//  - DONE: output_done=1 for exactly one cycle. -> IDLE.
//  Timing:
//  - fft_done sampled at edge k -> rd_en high cycle k+1 -> out_valid high from cycle k+3.
//  - Minimum 3 cycles/sample. Full frame with out_ready tied 1: 3*N_POINTS cycles, then 1 DONE cycle.
//  Counter width:
//  - samples_out_count_out is ADDR_W bits and wraps to 0 after the last sample (64 -> 0).
//  - It then holds 0 until the next frame starts.
//  Boundary conditions:
//  - out_valid never drops without a handshake.
//  - rd_en is never asserted outside FETCH.
//  - fft_done while busy: ignored, frame continues, overrun<=1 (sticky until next accepted start).
//  - fft_done in the DONE cycle: counts as busy -> overrun.
//  - out_ready while out_valid=0: ignored, no strobe.
//  - reset mid-frame: next edge returns to IDLE, all outputs 0, no output_done pulse.
// CONFIGURATION
//  Macro: FFT_OUT_BITREV_EN
//  - Defined: map(idx) = bit-reverse of idx over ADDR_W bits.
//    The RAM holds the frame in DIT bit-reversed order and is emitted in natural order.
//  - Undefined: map(idx) = idx (linear read); the RAM already holds natural order.
//  - All timing and handshakes are identical in both builds.
// TESTING
//  1. reset=1 for 2 cycles, then 0 -> all outputs 0, busy=0, state IDLE.
//  2. fft_done pulse, out_ready=1, RAM[a]=a:
//     - out_valid from cycle 3, 64 strobes, count 1..63 then 0.
//     - out_last on sample 63; output_done at cycle 193; busy=0 after.
//  3. BITREV build, same stimulus:
//     - rd_addr sequence 0,32,16,48,8... (idx1->32, idx3->48).
//     - out_data[1]=32, out_data[63]=63.
//  4. out_ready=0 for 10 cycles on sample 5 ->
//     - out_valid and out_data stay stable.
//     - No strobe or rd_en during the stall.
//     - Strobe on the first cycle out_ready=1.
//  5. Second fft_done at sample 20 -> overrun=1; frame completes all 64 samples; next fft_done in IDLE clears overrun.
//  6. reset asserted at sample 30 -> next cycle busy=0, out_valid=0, count=0, no output_done pulse.
//     New fft_done restarts from idx 0.

Source files
------------

// File: rtl/fft_output_sequencer.sv
// fft_output_sequencer: unloads a finished FFT frame from the result RAM onto a valid/ready stream.
// Define FFT_OUT_BITREV_EN to read the RAM in bit-reversed address order (DIT frame emitted in natural order).
module fft_output_sequencer #(
    parameter int N_POINTS = 64,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fft_done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_last,
    output logic                output_strobe,
    output logic                output_done,
    output logic [ADDR_W-1:0]   samples_out_count_out,
    output logic                busy,
    output logic                overrun
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                strobe_q, strobe_d;
    logic                ovr_q, ovr_d;
    logic [ADDR_W-1:0]   map_addr;
    logic                idx_last;
    logic                hs;

`ifdef FFT_OUT_BITREV_EN
    always_comb begin
        map_addr = '0;
        for (int b = 0; b < ADDR_W; b++) map_addr[b] = idx_q[ADDR_W-1-b];
    end
`else
    assign map_addr = idx_q;
`endif

    assign idx_last = idx_q == ADDR_W'(N_POINTS - 1);
    assign hs       = state_q == S_PRESENT && valid_q && out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        strobe_d = 1'b0;
        // a start request outside IDLE (including the DONE cycle) is dropped but remembered
        ovr_d    = ovr_q | (fft_done && state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (fft_done) begin
                state_d = S_FETCH;
                idx_d   = '0;
                count_d = '0;
                ovr_d   = 1'b0;
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                data_d  = rd_data;
                valid_d = 1'b1;
                last_d  = idx_last;
                state_d = S_PRESENT;
            end
            S_PRESENT: if (hs) begin
                strobe_d = 1'b1;
                valid_d  = 1'b0;
                last_d   = 1'b0;
                count_d  = count_q + 1'b1;
                idx_d    = idx_last ? idx_q : idx_q + 1'b1;
                state_d  = idx_last ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            strobe_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            strobe_q <= strobe_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rd_en                 = state_q == S_FETCH;
    assign rd_addr               = rd_en ? map_addr : '0;
    assign out_valid             = valid_q;
    assign out_data              = data_q;
    assign out_last              = last_q;
    assign output_strobe         = strobe_q;
    assign output_done           = state_q == S_DONE;
    assign samples_out_count_out = count_q;
    assign busy                  = state_q != S_IDLE;
    assign overrun               = ovr_q;
endmodule
